// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding, write-size codes,
// default timeout and the timeout-counter width helper.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IBUSY = 2'd1;
  localparam logic [1:0] ST_DBUSY = 2'd2;

  localparam logic [1:0] WSIZE_BYTE = 2'd0;
  localparam logic [1:0] WSIZE_HALF = 2'd1;
  localparam logic [1:0] WSIZE_WORD = 2'd2;

  localparam int DEF_TIMEOUT = 64;

  function automatic int ctr_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// Per-transaction busy-cycle counter: clears, counts while enabled, flags expiry at
// TIMEOUT-1 and holds there so it can never wrap.
module arb_timeout_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = ctr_width(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data ports, one request at a time.
// Define ARB_FAIRNESS_EN for round-robin on simultaneous requests; default is data-first.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] imem_rd_addr,
  input  logic              imem_rd_enable,
  output logic [DATA_W-1:0] imem_rd_data,
  output logic              imem_rd_ready,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_r_enable,
  input  logic              dmem_w_enable,
  input  logic [1:0]        dmem_w_size,
  input  logic [DATA_W-1:0] dmem_w_data,
  output logic [DATA_W-1:0] dmem_r_data,
  output logic              dmem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r_enable,
  output logic              mem_w_enable,
  output logic [1:0]        mem_w_size,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_ready,
  output logic              bus_err
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        w_size_q, w_size_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              is_write_q, is_write_d;

  logic i_busy, d_busy, busy, expired, done, abort, d_req, grant_d;

  assign i_busy = (state_q == ST_IBUSY);
  assign d_busy = (state_q == ST_DBUSY);
  assign busy   = i_busy || d_busy;
  assign d_req  = dmem_r_enable || dmem_w_enable;
  // A ready arriving on the expiry cycle wins: only a silent memory is aborted.
  assign done   = busy && (mem_ready || expired);
  assign abort  = busy && expired && !mem_ready;

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (reset),
    .clear   (!busy),
    .enable  (busy && !mem_ready),
    .expired (expired)
  );

`ifdef ARB_FAIRNESS_EN
  logic last_grant_q, last_grant_d;  // 1 = data port won the previous grant

  assign grant_d = d_req && (!imem_rd_enable || !last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == ST_IDLE) && (d_req || imem_rd_enable)) last_grant_d = grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b0;
    else       last_grant_q <= last_grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    w_size_d   = w_size_q;
    w_data_d   = w_data_q;
    is_write_d = is_write_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d    = ST_DBUSY;
          addr_d     = dmem_addr;
          w_size_d   = dmem_w_size;
          w_data_d   = dmem_w_data;
          is_write_d = dmem_w_enable;
        end else if (imem_rd_enable) begin
          state_d    = ST_IBUSY;
          addr_d     = imem_rd_addr;
          w_size_d   = '0;
          w_data_d   = '0;
          is_write_d = 1'b0;
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      w_size_q   <= '0;
      w_data_q   <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      w_size_q   <= w_size_d;
      w_data_q   <= w_data_d;
      is_write_q <= is_write_d;
    end
  end

  // Downstream request comes only from captured registers, so it is stable for the transaction.
  assign mem_addr     = busy ? addr_q : '0;
  assign mem_r_enable = i_busy || (d_busy && !is_write_q);
  assign mem_w_enable = d_busy && is_write_q;
  assign mem_w_size   = d_busy ? w_size_q : '0;
  assign mem_w_data   = d_busy ? w_data_q : '0;

  assign imem_rd_ready = i_busy && done;
  assign dmem_ready    = d_busy && done;
  assign imem_rd_data  = (i_busy && mem_ready) ? mem_r_data : '0;
  assign dmem_r_data   = (d_busy && mem_ready) ? mem_r_data : '0;
  assign bus_err       = abort;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory model, per-port driver
// tasks, and a response scoreboard fed by the stimulus and drained by a monitor.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int SW = 3 + DW;  // {imem_ready, dmem_ready, bus_err, owner data}

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_rd_addr;
  logic          imem_rd_enable;
  logic [DW-1:0] imem_rd_data;
  logic          imem_rd_ready;
  logic [AW-1:0] dmem_addr;
  logic          dmem_r_enable;
  logic          dmem_w_enable;
  logic [1:0]    dmem_w_size;
  logic [DW-1:0] dmem_w_data;
  logic [DW-1:0] dmem_r_data;
  logic          dmem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_r_enable;
  logic          mem_w_enable;
  logic [1:0]    mem_w_size;
  logic [DW-1:0] mem_w_data;
  logic [DW-1:0] mem_r_data;
  logic          mem_ready;
  logic          bus_err;

  int mem_lat;
  int strobe_cnt;
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [SW-1:0] exp_q[$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_addr   (imem_rd_addr),
    .imem_rd_enable (imem_rd_enable),
    .imem_rd_data   (imem_rd_data),
    .imem_rd_ready  (imem_rd_ready),
    .dmem_addr      (dmem_addr),
    .dmem_r_enable  (dmem_r_enable),
    .dmem_w_enable  (dmem_w_enable),
    .dmem_w_size    (dmem_w_size),
    .dmem_w_data    (dmem_w_data),
    .dmem_r_data    (dmem_r_data),
    .dmem_ready     (dmem_ready),
    .mem_addr       (mem_addr),
    .mem_r_enable   (mem_r_enable),
    .mem_w_enable   (mem_w_enable),
    .mem_w_size     (mem_w_size),
    .mem_w_data     (mem_w_data),
    .mem_r_data     (mem_r_data),
    .mem_ready      (mem_ready),
    .bus_err        (bus_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      32'h0000_0010: return 32'h0050_0093;
      32'h0000_0020: return 32'h00A0_0113;
      32'h0000_0040: return 32'h3333_4444;
      32'h0000_0100: return 32'h1111_2222;
      32'h0000_0500: return 32'h5555_6666;
      default:       return 32'h0;
    endcase
  endfunction

  // Memory model: ready in the mem_lat-th strobe cycle (never when mem_lat is 0).
  initial begin
    strobe_cnt = 0;
    mem_ready  = 1'b0;
    mem_r_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_r_enable || mem_w_enable) begin
        strobe_cnt = strobe_cnt + 1;
        mem_ready  = (mem_lat != 0) && (strobe_cnt == mem_lat);
        mem_r_data = (mem_ready && mem_r_enable) ? mem_word(mem_addr) : '0;
      end else begin
        strobe_cnt = 0;
        mem_ready  = 1'b0;
        mem_r_data = '0;
      end
    end
  end

  // Scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt = vec_cnt + 1;
    if (act !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic i_rdy, input logic d_rdy, input logic err,
                          input logic [DW-1:0] data);
    exp_q.push_back({i_rdy, d_rdy, err, data});
  endtask

  task automatic monitor_loop();
    logic [SW-1:0] act;
    logic [SW-1:0] exp;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && (imem_rd_ready || dmem_ready)) begin
        act = {imem_rd_ready, dmem_ready, bus_err, dmem_ready ? dmem_r_data : imem_rd_data};
        chk("other_port_data", dmem_ready ? imem_rd_data : dmem_r_data, 64'h0);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", act, 64'h0);
        end else begin
          exp = exp_q.pop_front();
          chk("sb_resp", act, exp);
        end
      end
    end
  endtask

  // Drivers
  task automatic start_fetch(input logic [AW-1:0] a);
    imem_rd_addr   = a;
    imem_rd_enable = 1'b1;
  endtask

  task automatic start_data(input logic [AW-1:0] a, input logic r, input logic w,
                            input logic [1:0] sz, input logic [DW-1:0] d);
    dmem_addr     = a;
    dmem_r_enable = r;
    dmem_w_enable = w;
    dmem_w_size   = sz;
    dmem_w_data   = d;
  endtask

  task automatic wait_rdy(input bit data_port);
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (data_port ? dmem_ready : imem_rd_ready) break;
    end
    if (n == 50) begin
      vec_cnt = vec_cnt + 1;
      err_cnt = err_cnt + 1;
      $display("FAIL wait_budget: port %0d got no ready within 50 cycles", data_port);
    end
    @(posedge clk);
    #1;
    if (data_port) begin
      dmem_r_enable = 1'b0;
      dmem_w_enable = 1'b0;
    end else begin
      imem_rd_enable = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_lat = 0;
    imem_rd_addr = '0; imem_rd_enable = 1'b0;
    dmem_addr = '0; dmem_r_enable = 1'b0; dmem_w_enable = 1'b0;
    dmem_w_size = '0; dmem_w_data = '0;
    fork
      monitor_loop();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {mem_r_enable, mem_w_enable, imem_rd_ready, dmem_ready, bus_err, mem_w_size}, 64'h0);
    chk("reset_addr_data", {mem_addr, mem_w_data}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Fetch only
    mem_lat = 2;
    push_exp(1'b1, 1'b0, 1'b0, 32'h0050_0093);
    start_fetch(32'h10);
    @(negedge clk);
    chk("fetch_arb_cycle", {mem_r_enable, mem_w_enable}, 64'h0);
    @(negedge clk);
    chk("fetch_strobe", {mem_r_enable, mem_w_enable, mem_addr}, {2'b10, 32'h10});
    wait_rdy(0);

    // Simultaneous fetch and load: data first, fetch after one idle cycle
    mem_lat = 2;
    push_exp(1'b0, 1'b1, 1'b0, 32'h1111_2222);
    push_exp(1'b1, 1'b0, 1'b0, 32'h00A0_0113);
    start_fetch(32'h20);
    start_data(32'h100, 1'b1, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("prio_data_first", {mem_r_enable, mem_w_enable, mem_addr}, {2'b10, 32'h100});
    wait_rdy(1);
    @(negedge clk);
    chk("gap_idle", {mem_r_enable, mem_w_enable}, 64'h0);
    @(negedge clk);
    chk("fetch_after_gap", {mem_r_enable, mem_w_enable, mem_addr}, {2'b10, 32'h20});
    wait_rdy(0);

    // Store with a 5-cycle memory: request held constant
    mem_lat = 5;
    push_exp(1'b0, 1'b1, 1'b0, 32'h0);
    start_data(32'h200, 1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("store_ctl_addr", {mem_w_enable, mem_r_enable, mem_w_size, mem_addr},
          {1'b1, 1'b0, 2'd2, 32'h200});
      chk("store_wdata", mem_w_data, 32'hDEAD_BEEF);
    end
    @(posedge clk);
    #1 dmem_w_enable = 1'b0;

    // Read and write both high: a write
    mem_lat = 1;
    push_exp(1'b0, 1'b1, 1'b0, 32'h0);
    start_data(32'h300, 1'b1, 1'b1, 2'd0, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    chk("rw_is_write", {mem_w_enable, mem_r_enable, mem_addr}, {2'b10, 32'h300});
    @(posedge clk);
    #1;
    dmem_r_enable = 1'b0;
    dmem_w_enable = 1'b0;

    // Timeout on a silent memory, with a fetch queued behind it
    mem_lat = 0;
    push_exp(1'b0, 1'b1, 1'b1, 32'h0);
    push_exp(1'b1, 1'b0, 1'b0, 32'h3333_4444);
    start_fetch(32'h40);
    start_data(32'h400, 1'b1, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      chk("timeout_pulse", {bus_err, dmem_ready}, (i == TO) ? 2'b11 : 2'b00);
    end
    @(posedge clk);
    #1;
    dmem_r_enable = 1'b0;
    mem_lat = 2;
    wait_rdy(0);

    // Ready on the expiry cycle is a normal completion
    mem_lat = TO;
    push_exp(1'b0, 1'b1, 1'b0, 32'h5555_6666);
    start_data(32'h500, 1'b1, 1'b0, 2'd0, 32'h0);
    wait_rdy(1);

    // Asynchronous reset in the middle of a data transaction
    mem_lat = 0;
    start_data(32'h600, 1'b1, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_reset", {mem_r_enable, mem_addr}, {1'b1, 32'h600});
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ctl", {mem_r_enable, mem_w_enable, imem_rd_ready, dmem_ready, bus_err, mem_w_size}, 64'h0);
    chk("async_reset_addr", mem_addr, 64'h0);
    dmem_r_enable = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {mem_r_enable, mem_w_enable}, 64'h0);
    mem_lat = 2;
    push_exp(1'b1, 1'b0, 1'b0, 32'h0050_0093);
    start_fetch(32'h10);
    wait_rdy(0);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one unified memory port between the core's instruction-fetch port and its data-access port.
Sits between minuteCore and a single-ported memory model, replacing the separate imem/dmem pair in the unified-memory build.
Captures one request at a time and holds it stable downstream until the memory signals ready, then routes the response back to the owning requester.
Includes a per-transaction timeout counter that aborts hung accesses.

Parameters:
ADDR_W, 32, address width in bits (matches `ADDR_SIZE+1)
DATA_W, 32, data/instruction width in bits (matches `INSTR_SIZE+1)
TIMEOUT, 64, max busy cycles waiting for mem_ready before abort; must be ≥2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
imem_rd_addr  in  ADDR_W  fetch address
imem_rd_enable  in  1  fetch request; held high until imem_rd_ready
imem_rd_data  out  DATA_W  fetched instruction
imem_rd_ready  out  1  one-cycle fetch completion
dmem_addr  in  ADDR_W  data address
dmem_r_enable  in  1  data read request; held until dmem_ready
dmem_w_enable  in  1  data write request; held until dmem_ready
dmem_w_size  in  2  write size: 0 byte, 1 half, 2 word
dmem_w_data  in  DATA_W  write data
dmem_r_data  out  DATA_W  read data
dmem_ready  out  1  one-cycle data completion
mem_addr  out  ADDR_W  downstream address
mem_r_enable  out  1  downstream read strobe
mem_w_enable  out  1  downstream write strobe
mem_w_size  out  2  downstream write size
mem_w_data  out  DATA_W  downstream write data
mem_r_data  in  DATA_W  downstream read data
mem_ready  in  1  downstream completion
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- FSM states IDLE, IBUSY, DBUSY. Reset (asynchronous, any state) → IDLE. All registered outputs are 0 on reset; timeout counter = 0. Any in-flight memory access is abandoned.
- IDLE: sample the request enables.
  - Data request pending (r or w) → capture addr/w_size/w_data/type and go to DBUSY.
  - Else imem_rd_enable → capture addr and go to IBUSY.
  - Both pending → data wins (fixed priority).
  - r_enable and w_enable both high → treated as a write.
- BUSY: mem_* are driven from the captured registers, constant for the whole transaction; mem strobes are 0 in IDLE. The strobe asserts in the cycle after the request is first seen (minimum 1 cycle arbitration latency).
- Completion: when mem_ready=1 in BUSY, the owner's ready is asserted combinationally in that same cycle. Its r_data = mem_r_data; the non-owner's data output is 0. FSM → IDLE at that edge. The requester drops or renews its enable at the same edge.
- A request made during the other's transaction waits. It is served from IDLE next, giving back-to-back transactions at 1 IDLE cycle gap.
- mem_ready while IDLE is ignored.
- Timeout: the counter clears on entry to BUSY and increments each BUSY cycle without mem_ready. Reaching TIMEOUT-1 without ready → bus_err=1 and owner ready=1 for one cycle, with data 0; FSM → IDLE.
- mem_ready arriving in the same cycle as the timeout → treated as a normal completion; bus_err stays 0.
- Counter width is clog2(TIMEOUT); no wrap-around is possible.

Optional Feature:
ARB_FAIRNESS_EN.
- Defined: a last_grant flag is reset to instruction. On a simultaneous request, grant goes to the port not granted last (round-robin), so fetch cannot be starved by consecutive loads/stores.
- Undefined: fixed data-over-instruction priority, and no last_grant register is generated.

Decomposition:
- Shared package (def_params): state encoding (IDLE=0, IBUSY=1, DBUSY=2), w_size codes, default TIMEOUT.
- One natural sub-module: arb_timeout_ctr (clear/enable/expire), reusable by future bus bridges.
- The remainder is a single FSM module.

Test Plan:
- Fetch only: imem_rd_addr=0x10 held high, memory ready after 2 cycles with data 0x00500093 → mem_r_enable at cycle 1; imem_rd_ready for one cycle with data 0x00500093; dmem_ready stays 0.
- Simultaneous fetch 0x20 and load 0x100 → load is served first (mem_addr=0x100), then fetch 0x20 after 1 IDLE cycle. With ARB_FAIRNESS_EN and last_grant=data, fetch is served first.
- Store 0xDEADBEEF, size 2, to 0x200 while mem_ready is delayed 5 cycles → mem_addr, mem_w_data and mem_w_size stay constant for all 5 cycles; dmem_ready pulses once.
- mem_ready never asserted, TIMEOUT=8 → bus_err and dmem_ready pulse at busy cycle 8; dmem_r_data=0; the next pending fetch proceeds normally.
- Reset asserted mid-DBUSY → all outputs 0 immediately (asynchronously); after release, FSM is in IDLE and a fresh fetch completes normally.
- r_enable and w_enable both high at 0x300 → a write is issued (mem_w_enable=1, mem_r_enable=0).
